// File: rtl/dca_matrix_row_stream_ctrl_pkg.sv
// rtl/dca_matrix_row_stream_ctrl_pkg.sv - command/state encodings and sizing helpers for the row stream controller
package dca_matrix_row_stream_ctrl_pkg;

  // Command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    DCA_RSC_OP_LOAD  = 2'd0,
    DCA_RSC_OP_DRAIN = 2'd1,
    DCA_RSC_OP_SWAP  = 2'd2,
    DCA_RSC_OP_CLEAR = 2'd3
  } dca_rsc_op_e;

  // Sequencer states; one op state per command
  typedef enum logic [2:0] {
    DCA_RSC_ST_IDLE  = 3'd0,
    DCA_RSC_ST_LOAD  = 3'd1,
    DCA_RSC_ST_DRAIN = 3'd2,
    DCA_RSC_ST_SWAP  = 3'd3,
    DCA_RSC_ST_CLEAR = 3'd4
  } dca_rsc_state_e;

  // Matrix size code -> number of rows (the code is the row count of the square matrix)
  function automatic int dca_matrix_num_row(input int size_para);
    return size_para;
  endfunction

  // Row width in bits for a square matrix of the given size code
  function automatic int dca_tensor_row_bits(input int size_para, input int bw_scalar);
    return dca_matrix_num_row(size_para) * bw_scalar;
  endfunction

endpackage

// File: rtl/dca_matrix_row_stream_ctrl_if.sv
// rtl/dca_matrix_row_stream_ctrl_if.sv - command, row stream and matrix register move-port bundle
interface dca_matrix_row_stream_ctrl_if
  import dca_matrix_row_stream_ctrl_pkg::*;
#(
  parameter int BW_TENSOR_ROW = 256
);
  // command channel
  logic                     cmd_valid;
  logic                     cmd_ready;
  dca_rsc_op_e              cmd_op;
  // input row stream
  logic                     in_valid;
  logic                     in_ready;
  logic [BW_TENSOR_ROW-1:0] in_data;
  // output row stream
  logic                     out_valid;
  logic                     out_ready;
  logic [BW_TENSOR_ROW-1:0] out_data;
  // matrix register row-move port
  logic                     mreg_init;
  logic                     mreg_move_wenable;
  logic [BW_TENSOR_ROW-1:0] mreg_move_wdata_list;
  logic                     mreg_move_renable;
  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list;

  // master: the side issuing commands, supplying rows and hosting the register
  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, out_ready, mreg_move_rdata_list,
    input  cmd_ready, in_ready, out_valid, out_data,
           mreg_init, mreg_move_wenable, mreg_move_wdata_list, mreg_move_renable
  );

  // slave: the controller
  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, out_ready, mreg_move_rdata_list,
    output cmd_ready, in_ready, out_valid, out_data,
           mreg_init, mreg_move_wenable, mreg_move_wdata_list, mreg_move_renable
  );

endinterface

// File: rtl/dca_matrix_row_stream_ctrl.sv
// rtl/dca_matrix_row_stream_ctrl.sv - LOAD/DRAIN/SWAP/CLEAR row-move sequencer for the matrix register
module dca_matrix_row_stream_ctrl
  import dca_matrix_row_stream_ctrl_pkg::*;
#(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_TENSOR_SCALAR = 32
) (
  input  logic                   clk_i,
  input  logic                   rstp_i,
  dca_matrix_row_stream_ctrl_if.slave bus,
  output logic                   ctrl_busy_o,
  output logic                   ctrl_done_o,
  output logic [$clog2(dca_matrix_num_row(MATRIX_SIZE_PARA)+1)-1:0] rows_valid_o
);

  localparam int MATRIX_NUM_ROW = dca_matrix_num_row(MATRIX_SIZE_PARA);
  localparam int BW_TENSOR_ROW  = dca_tensor_row_bits(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR);
  localparam int BW_ROW_CNT     = $clog2(MATRIX_NUM_ROW + 1);
  localparam logic [BW_ROW_CNT-1:0] LAST_ROW = BW_ROW_CNT'(MATRIX_NUM_ROW - 1);
  localparam logic [BW_ROW_CNT-1:0] ROW_MAX  = BW_ROW_CNT'(MATRIX_NUM_ROW);

  dca_rsc_state_e          state_q;
  logic [BW_ROW_CNT-1:0]   row_cnt_q;
  logic [BW_ROW_CNT-1:0]   rows_valid_q;

  logic st_idle, st_load, st_drain, st_swap, st_clear;
  logic beat_load, beat_drain, beat_swap, last_beat;

  // State decode and per-state beat qualification
  always_comb begin
    st_idle    = (state_q == DCA_RSC_ST_IDLE);
    st_load    = (state_q == DCA_RSC_ST_LOAD);
    st_drain   = (state_q == DCA_RSC_ST_DRAIN);
    st_swap    = (state_q == DCA_RSC_ST_SWAP);
    st_clear   = (state_q == DCA_RSC_ST_CLEAR);
    beat_load  = st_load  & bus.in_valid;
    beat_drain = st_drain & bus.out_ready;
    beat_swap  = st_swap  & bus.in_valid & bus.out_ready;
    last_beat  = (beat_load | beat_drain | beat_swap) & (row_cnt_q == LAST_ROW);
  end

  // Handshake and register-port drive; idle states never touch the move enables
  always_comb begin
    bus.cmd_ready            = st_idle;
    bus.in_ready             = st_load | (st_swap & bus.out_ready);
    bus.out_valid            = st_drain | (st_swap & bus.in_valid);
    bus.out_data             = (st_drain | st_swap) ? bus.mreg_move_rdata_list
                                                    : {BW_TENSOR_ROW{1'b0}};
    bus.mreg_move_wenable    = beat_load | beat_swap;
    bus.mreg_move_wdata_list = (st_load | st_swap) ? bus.in_data : {BW_TENSOR_ROW{1'b0}};
    bus.mreg_move_renable    = beat_drain | beat_swap;
    bus.mreg_init            = st_clear;
    ctrl_busy_o              = ~st_idle;
    ctrl_done_o              = last_beat | st_clear;
    rows_valid_o             = rows_valid_q;
  end

  // Sequencer: command dispatch, row counting and occupancy tracking
  always_ff @(posedge clk_i) begin
    if (rstp_i) begin
      state_q      <= DCA_RSC_ST_IDLE;
      row_cnt_q    <= '0;
      rows_valid_q <= '0;
    end else begin
      case (state_q)
        DCA_RSC_ST_IDLE: begin
          if (bus.cmd_valid) begin
            row_cnt_q <= '0;
            case (bus.cmd_op)
              DCA_RSC_OP_LOAD:  state_q <= DCA_RSC_ST_LOAD;
              DCA_RSC_OP_DRAIN: state_q <= DCA_RSC_ST_DRAIN;
              DCA_RSC_OP_SWAP:  state_q <= DCA_RSC_ST_SWAP;
              default:          state_q <= DCA_RSC_ST_CLEAR;
            endcase
          end
        end
        DCA_RSC_ST_LOAD: begin
          if (beat_load) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (rows_valid_q != ROW_MAX) rows_valid_q <= rows_valid_q + 1'b1;
            if (last_beat) state_q <= DCA_RSC_ST_IDLE;
          end
        end
        DCA_RSC_ST_DRAIN: begin
          if (beat_drain) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (rows_valid_q != '0) rows_valid_q <= rows_valid_q - 1'b1;
            if (last_beat) state_q <= DCA_RSC_ST_IDLE;
          end
        end
        DCA_RSC_ST_SWAP: begin
          if (beat_swap) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (last_beat) begin
              rows_valid_q <= ROW_MAX;
              state_q      <= DCA_RSC_ST_IDLE;
            end
          end
        end
        default: begin
          rows_valid_q <= '0;
          state_q      <= DCA_RSC_ST_IDLE;
        end
      endcase
    end
  end

endmodule
